temp_filter: RTL and testbench



---
 rtl/temp_filter_pkg.sv | 9 +
 rtl/temp_filter_rise_det.sv | 13 +
 rtl/temp_filter.sv | 84 ++++++++
 tb/tb_temp_filter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/temp_filter_pkg.sv
// temp_filter_pkg: shared types and constants for the DS18B20 reading filter
package temp_filter_pkg;
  typedef enum logic {EMPTY, RUN} state_t;
  localparam int TEMP_W = 12;
  localparam logic [TEMP_W-1:0] DS_POWERON_VAL = 12'h550;
  function automatic int calc_sh(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/temp_filter_rise_det.sv
// temp_filter_rise_det: one-cycle strobe on each rising edge of a level input
module temp_filter_rise_det (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);
  logic prev;
  always_ff @(posedge clk or posedge rst)
    if (rst) prev <= 1'b0;
    else prev <= level;
  assign rise = level & ~prev;
endmodule

// File: rtl/temp_filter.sv
// temp_filter: spike-rejecting moving average over DS18B20 readings
module temp_filter
  import temp_filter_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int MAX_STEP = 32,
  parameter int REJECT_LIMIT = 3,
  parameter int DISCARD_85 = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TEMP_W-1:0] raw_temp,
  input  logic              raw_done,
  output logic [TEMP_W-1:0] filt_temp,
  output logic              filt_valid,
  output logic              seeded,
  output logic              step_fault
);
  localparam int SH = calc_sh(DEPTH);
  localparam int SUM_W = TEMP_W + SH;
  localparam logic [12:0] MAX_D = 13'(MAX_STEP);
  localparam logic [2:0] LIM_M1 = 3'(REJECT_LIMIT - 1);
  state_t state_q, state_d;
  logic [TEMP_W-1:0] mem [DEPTH];
  logic [SUM_W-1:0] sum;
  logic [SH-1:0] wptr;
  logic [2:0] rej_cnt;
  logic [TEMP_W-1:0] avg;
  logic [12:0] d, diff;
  logic rise, seed, reseed, acc, rej, upd;
  temp_filter_rise_det u_rise (.clk(clk), .rst(rst), .level(raw_done), .rise(rise));
  assign avg = TEMP_W'(sum >> SH);
  assign d = {1'b0, raw_temp} - {1'b0, avg};
  assign diff = d[12] ? 13'd0 - d : d;
  always_comb begin
    seed = 1'b0;
    reseed = 1'b0;
    acc = 1'b0;
    rej = 1'b0;
    if (rise) begin
      if (state_q == EMPTY) seed = !(DISCARD_85 != 0 && raw_temp == DS_POWERON_VAL);
      else if (diff <= MAX_D) acc = 1'b1;
      else if (rej_cnt < LIM_M1) rej = 1'b1;
      else begin
        seed = 1'b1;
        reseed = 1'b1;
      end
    end
    state_d = seed ? RUN : state_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= EMPTY;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      sum <= '0;
      wptr <= '0;
      rej_cnt <= '0;
      upd <= 1'b0;
      filt_temp <= '0;
      filt_valid <= 1'b0;
      seeded <= 1'b0;
      step_fault <= 1'b0;
    end else begin
      state_q <= state_d;
      upd <= seed | acc;
      filt_valid <= upd;
      if (upd) filt_temp <= avg;
      if (reseed) step_fault <= 1'b1;
      if (seed) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= raw_temp;
        sum <= SUM_W'(raw_temp) << SH;
        wptr <= '0;
        rej_cnt <= '0;
        seeded <= 1'b1;
      end
      if (acc) begin
        sum <= sum - SUM_W'(mem[wptr]) + SUM_W'(raw_temp);
        mem[wptr] <= raw_temp;
        wptr <= wptr + 1'b1;
        rej_cnt <= '0;
      end
      if (rej) rej_cnt <= rej_cnt + 3'd1;
    end
endmodule

// File: tb/tb_temp_filter.sv
// tb_temp_filter: randomized scoreboard bench for temp_filter against a windowed-average model
module tb_temp_filter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [11:0] raw_temp = '0;
  logic raw_done = 1'b0;
  logic [11:0] filt_temp;
  logic filt_valid, seeded, step_fault;
  temp_filter dut (
    .clk(clk), .rst(rst), .raw_temp(raw_temp), .raw_done(raw_done),
    .filt_temp(filt_temp), .filt_valid(filt_valid), .seeded(seeded), .step_fault(step_fault)
  );
  always #5 clk = ~clk;
  typedef struct {int temp; int at;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  int win[$];
  bit m_seeded, m_fault;
  int m_rej, hold_v, cyc, tests, fails;
  initial begin
    cyc = 0; tests = 0; fails = 0; hold_v = 0;
  end
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, cyc);
    end
  endtask
  function automatic int m_avg();
    int s = 0;
    foreach (win[i]) s += win[i];
    return s / 8;
  endfunction
  function automatic void m_seed(input int v, input int c);
    win.delete();
    repeat (8) win.push_back(v);
    m_seeded = 1; m_rej = 0;
    q.push_back('{v, c + 2});
  endfunction
  function automatic void model(input int v, input int c);
    int df;
    if (!m_seeded) begin
      if (v != 'h550) m_seed(v, c);
      return;
    end
    df = v - m_avg();
    if (df < 0) df = -df;
    if (df <= 32) begin
      void'(win.pop_front());
      win.push_back(v);
      m_rej = 0;
      q.push_back('{m_avg(), c + 2});
    end else if (m_rej + 1 < 3) m_rej++;
    else begin
      m_seed(v, c);
      m_fault = 1;
    end
  endfunction
  function automatic void model_reset();
    win.delete(); q.delete();
    m_seeded = 0; m_fault = 0; m_rej = 0; hold_v = 0;
  endfunction
  always @(negedge clk) if (!rst) begin
    if (filt_valid) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_pulse: got filt_temp %0h expected no pulse at cycle %0d", filt_temp, cyc);
      end else begin
        mon_e = q.pop_front();
        chk("pulse_temp", int'(filt_temp), mon_e.temp);
        chk("pulse_cycle", cyc, mon_e.at);
        hold_v = mon_e.temp;
      end
    end else chk("hold_temp", int'(filt_temp), hold_v);
  end
  task automatic ev(input int v);
    @(posedge clk); #1;
    raw_temp = 12'(v); raw_done = 1'b1;
    model(v, cyc);
    @(posedge clk); #1;
    raw_done = 1'b0;
    raw_temp = 12'(v) ^ 12'hA5A;
    chk("seeded", int'(seeded), int'(m_seeded));
    chk("step_fault", int'(step_fault), int'(m_fault));
  endtask
  task automatic check_zero(input string n);
    chk({n, "_temp"}, int'(filt_temp), 0);
    chk({n, "_valid"}, int'(filt_valid), 0);
    chk({n, "_seeded"}, int'(seeded), 0);
    chk({n, "_fault"}, int'(step_fault), 0);
  endtask
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; raw_done = 1'b0;
    model_reset();
    #1 check_zero("reset");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask
  initial begin
    int v, a;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_zero("por");
    #1 rst = 1'b0;
    ev('h550);
    ev('h190);
    repeat (8) ev('h1A0);
    do_reset();
    ev('h190);
    ev('h300);
    ev('h1B0);
    repeat (3) ev('h300);
    repeat (3) ev('h310);
    @(posedge clk); #1;
    raw_temp = 12'h30C; raw_done = 1'b1;
    model('h30C, cyc);
    @(posedge clk); #1 raw_temp = 12'h0F0;
    repeat (99) @(posedge clk);
    #1 raw_done = 1'b0;
    repeat (4) @(posedge clk);
    @(posedge clk); #1;
    raw_temp = 12'h308; raw_done = 1'b1;
    @(posedge clk); #1;
    raw_done = 1'b0; rst = 1'b1;
    model_reset();
    #1 check_zero("mid_reset");
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      a = m_avg();
      case ($urandom_range(0, 19))
        0: v = 'h550;
        1, 2, 3: v = $urandom_range(0, 4095);
        default: v = a + $urandom_range(0, 80) - 40;
      endcase
      if (v < 0) v = 0;
      if (v > 4095) v = 4095;
      if ($urandom_range(0, 49) == 0) do_reset();
      ev(v);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    repeat (5) @(posedge clk);
    #1 chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end
endmodule
